// File: rtl/router_pkg.sv
// router_pkg: shared constants and route decode for the XY mesh router.
//   port_e       : port indices (LOCAL, EAST, WEST, NORTH, SOUTH)
//   NUM_PORTS    : number of router ports
//   DEF_*        : default packet field widths
//   route_decode : dimension-ordered (X first, then Y) output selection
package router_pkg;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      EAST  = 3'd1,
      WEST  = 3'd2,
      NORTH = 3'd3,
      SOUTH = 3'd4
   } port_e;

   localparam int unsigned NUM_PORTS  = 5;
   localparam int unsigned DEF_DATA_W = 40;
   localparam int unsigned DEF_X_W    = 3;
   localparam int unsigned DEF_Y_W    = 1;

   function automatic port_e route_decode(input int unsigned dx,
                                          input int unsigned dy,
                                          input int unsigned lx,
                                          input int unsigned ly);
      if (dx > lx)      return EAST;
      else if (dx < lx) return WEST;
      else if (dy < ly) return NORTH;
      else if (dy > ly) return SOUTH;
      else              return LOCAL;
   endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: synchronous FIFO used as one router input buffer.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored while full)
//   pop        : discard head entry (ignored while empty)
//   head       : oldest entry, valid when !empty
//   count      : number of stored entries (0..DEPTH)
//   full/empty : count == DEPTH / count == 0
module router_fifo #(
   parameter int unsigned WIDTH = 44,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

   // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/router_xy_mesh.sv
// router_xy_mesh: 5-port dimension-ordered (XY) mesh router.
// Each input has a small FIFO; each output has a round-robin arbiter and a
// single output register with valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : per-port packet valid (0 LOCAL, 1 EAST, 2 WEST, 3 NORTH, 4 SOUTH)
//   in_ready  : per-port input FIFO has room (from registered count)
//   in_pack   : per-port packet {dest_y, dest_x, payload}
//   out_valid : per-port output register holds a packet
//   out_ready : per-port downstream accept
//   out_pack  : per-port outgoing packet (LOCAL carries payload only)
module router_xy_mesh
   import router_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned X_W        = DEF_X_W,
   parameter int unsigned Y_W        = DEF_Y_W,
   parameter int unsigned PACK_W     = DATA_W + X_W + Y_W,
   parameter int unsigned LOCAL_X    = 0,
   parameter int unsigned LOCAL_Y    = 0,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_PORTS-1:0]               in_valid,
   output logic [NUM_PORTS-1:0]               in_ready,
   input  logic [NUM_PORTS-1:0][PACK_W-1:0]   in_pack,
   output logic [NUM_PORTS-1:0]               out_valid,
   input  logic [NUM_PORTS-1:0]               out_ready,
   output logic [NUM_PORTS-1:0][PACK_W-1:0]   out_pack
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_PORTS-1:0][PACK_W-1:0] head;
   logic [NUM_PORTS-1:0][CNT_W-1:0]  count;
   logic [NUM_PORTS-1:0]             full, empty, push, pop;
   port_e                            route [NUM_PORTS];

   logic [NUM_PORTS-1:0]             out_valid_q, out_valid_d;
   logic [NUM_PORTS-1:0][PACK_W-1:0] out_pack_q, out_pack_d;
   logic [NUM_PORTS-1:0][2:0]        rr_ptr_q, rr_ptr_d;

   logic       arb_found;
   logic [2:0] arb_gsel, arb_idx;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
      router_fifo #(
         .WIDTH (PACK_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push[i]),
         .push_data (in_pack[i]),
         .pop       (pop[i]),
         .head      (head[i]),
         .count     (count[i]),
         .full      (full[i]),
         .empty     (empty[i])
      );

      assign in_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH));
      assign push[i]     = in_valid[i] & ~full[i];
      assign route[i]    = route_decode(32'(head[i][PACK_W-Y_W-1 -: X_W]),
                                        32'(head[i][PACK_W-1 -: Y_W]),
                                        LOCAL_X, LOCAL_Y);
   end

   // Every head targets exactly one output, so per-output grants never
   // collide on the same FIFO and pops can simply be OR-ed together.
   always_comb begin
      pop         = '0;
      out_valid_d = out_valid_q;
      out_pack_d  = out_pack_q;
      rr_ptr_d    = rr_ptr_q;
      arb_found   = 1'b0;
      arb_gsel    = '0;
      arb_idx     = '0;
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
         arb_found = 1'b0;
         arb_gsel  = '0;
         for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            arb_idx = 3'((32'(rr_ptr_q[o]) + k) % NUM_PORTS);
            if (!arb_found && !empty[arb_idx] && (32'(route[arb_idx]) == o)) begin
               arb_found = 1'b1;
               arb_gsel  = arb_idx;
            end
         end
         if (!out_valid_q[o] || out_ready[o]) begin
            out_valid_d[o] = arb_found;
            if (arb_found) begin
               pop[arb_gsel] = 1'b1;
               rr_ptr_d[o]   = 3'((32'(arb_gsel) + 1) % NUM_PORTS);
               if (o == 32'(LOCAL)) begin
                  out_pack_d[o] = {{(PACK_W-DATA_W){1'b0}}, head[arb_gsel][DATA_W-1:0]};
               end else begin
                  out_pack_d[o] = head[arb_gsel];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= '0;
         out_pack_q  <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_pack_q  <= out_pack_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pack  = out_pack_q;

endmodule
